// File: rtl/prefetch_pkg.sv
// Shared definitions for the instruction prefetcher: FSM state encoding and PC step.
package prefetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } state_t;

   localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/prefetch_unit_if.sv
// Memory strobe/busy bus plus core-side pop/redirect signals of the prefetcher.
interface prefetch_unit_if #(
   parameter int ADDR_WIDTH = 24
);
   logic [31:0]           mem_addr;
   logic                  mem_rstrb;
   logic [31:0]           mem_rdata;
   logic                  mem_rbusy;
   logic                  fetch_hold;
   logic                  fetch_idle;
   logic                  instr_valid;
   logic [31:0]           instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_ready;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;

   modport master (
      output mem_addr, mem_rstrb, fetch_idle, instr_valid, instr, instr_pc,
      input  mem_rdata, mem_rbusy, fetch_hold, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_addr, mem_rstrb, fetch_idle, instr_valid, instr, instr_pc,
      output mem_rdata, mem_rbusy, fetch_hold, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs; flush wins over push and pop.
module prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 56
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == FULL_CNT);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rdata     = r_mem[r_rd_ptr];
   assign w_do_push = push && !full && !flush;
   assign w_do_pop  = pop && !empty && !flush;

   // NOTE: storage carries no reset; empty/count gate every read, so only pointers need one.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
      end
   end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: fills a DEPTH-entry queue over the strobe/busy bus, pops to the core.
module prefetch_unit
   import prefetch_pkg::*;
#(
   parameter int          ADDR_WIDTH = 24,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          DEPTH      = 4
) (
   input  logic            clk,
   input  logic            reset,
   prefetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = ADDR_WIDTH + 32;
   localparam logic [ADDR_WIDTH-1:0] RESET_PC = RESET_ADDR[ADDR_WIDTH-1:0];
   localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] w_fetch_pc_next;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [CW-1:0]         w_count;
   logic [CW-1:0]         w_count_on_push;
   logic [EW-1:0]         w_head;

   // A redirect discards any coincident pop along with the whole queue.
   assign w_pop           = !w_empty && bus.instr_ready && !bus.redirect_valid;
   assign w_count_on_push = w_count + CW'(1) - CW'(w_pop);

   prefetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .flush (bus.redirect_valid),
      .wdata ({r_fetch_pc, bus.mem_rdata}),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      w_push          = 1'b0;
      case (r_state)
         IDLE: if (!w_full && !bus.fetch_hold) w_state_next = REQ;
         REQ:  w_state_next = WAIT;
         WAIT: begin
            if (!bus.mem_rbusy) begin
               w_push          = 1'b1;
               w_fetch_pc_next = r_fetch_pc + ADDR_WIDTH'(PC_INC);
               w_state_next    = (w_count_on_push < DEPTH_CNT && !bus.fetch_hold) ? REQ : IDLE;
            end
         end
         DROP: if (!bus.mem_rbusy) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase

      // The strobe may already be out, so a pending read is drained in DROP.
      if (bus.redirect_valid) begin
         w_push          = 1'b0;
         w_fetch_pc_next = bus.redirect_pc & ~ADDR_WIDTH'(3);
         case (r_state)
            REQ:     w_state_next = DROP;
            WAIT:    w_state_next = bus.mem_rbusy ? DROP : IDLE;
            default: w_state_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_PC;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
      end
   end

   assign bus.mem_addr    = 32'(r_fetch_pc);
   assign bus.mem_rstrb   = (r_state == REQ);
   assign bus.fetch_idle  = (r_state == IDLE);
   assign bus.instr_valid = !w_empty;
   assign bus.instr_pc    = w_head[EW-1:32];
   assign bus.instr       = w_head[31:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: fill-phase vector table, directed corner sequences, random run vs stream model.
module tb_prefetch_unit;
   import prefetch_pkg::*;

   localparam int          AW      = 24;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

   typedef struct {
      bit          ready;
      bit          hold;
      bit          rstrb;
      bit          idle;
      bit          valid;
      logic [31:0] addr;
      logic [23:0] pc;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   prefetch_unit_if #(.ADDR_WIDTH(AW)) mif ();

   prefetch_unit #(
      .ADDR_WIDTH (AW),
      .RESET_ADDR (32'h0000_0000),
      .DEPTH      (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   // Memory model: data word is the address xor a key; busy for mem_wait cycles after a strobe.
   logic [31:0] mem_lat_addr;
   int unsigned mem_busy_left;
   int unsigned mem_wait;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_lat_addr  <= 32'h0;
         mem_busy_left <= 0;
      end else if (mif.mem_rstrb) begin
         mem_lat_addr  <= mif.mem_addr;
         mem_busy_left <= mem_wait;
      end else if (mem_busy_left != 0) begin
         mem_busy_left <= mem_busy_left - 1;
      end
   end

   assign mif.mem_rbusy = (mem_busy_left != 0);
   assign mif.mem_rdata = mem_lat_addr ^ XOR_KEY;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_pops   = 0;
   int          n_strobe = 0;
   int          fill_strobes = 0;
   logic [AW-1:0] exp_pc;
   vec_t        vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: scores a pop against the expected sequential stream, then applies the edge.
   task automatic tick();
      bit do_pop;
      bit was_redir;
      bit was_hold;
      bit was_strobe;
      do_pop     = mif.instr_valid && mif.instr_ready && !mif.redirect_valid;
      was_redir  = mif.redirect_valid;
      was_hold   = mif.fetch_hold;
      was_strobe = mif.mem_rstrb;
      if (do_pop) begin
         check("pop_pc", 32'(mif.instr_pc), 32'(exp_pc));
         check("pop_instr", mif.instr, 32'(exp_pc) ^ XOR_KEY);
         exp_pc = exp_pc + AW'(4);
         n_pops++;
      end
      if (was_redir) exp_pc = {mif.redirect_pc[AW-1:2], 2'b00};
      @(posedge clk);
      @(negedge clk);
      if (mif.mem_rstrb) n_strobe++;
      if (was_redir)  check("valid_after_redirect", mif.instr_valid, 1'b0);
      if (was_hold)   check("no_strobe_under_hold", mif.mem_rstrb, 1'b0);
      if (was_strobe) check("strobe_one_cycle", mif.mem_rstrb, 1'b0);
   endtask

   task automatic do_reset();
      reset              = 1'b0;
      mif.instr_ready    = 1'b0;
      mif.fetch_hold     = 1'b0;
      mif.redirect_valid = 1'b0;
      mif.redirect_pc    = '0;
      repeat (2) @(negedge clk);
      exp_pc   = '0;
      n_strobe = 0;
      reset    = 1'b1;
   endtask

   task automatic wait_strobe(input int max_cycles, input string name);
      int i;
      i = 0;
      while (!mif.mem_rstrb && i < max_cycles) begin
         tick();
         i++;
      end
      check(name, mif.mem_rstrb, 1'b1);
   endtask

   task automatic wait_valid(input int max_cycles, input string name);
      int i;
      i = 0;
      while (!mif.instr_valid && i < max_cycles) begin
         tick();
         i++;
      end
      check(name, mif.instr_valid, 1'b1);
   endtask

   task automatic wait_pops(input int target, input int max_cycles, input string name);
      int i;
      i = 0;
      while (n_pops < target && i < max_cycles) begin
         tick();
         i++;
      end
      check(name, n_pops >= target, 1'b1);
   endtask

   initial begin
      // Outputs after edge k of a zero-wait fill with instr_ready low, then one pop.
      vecs[0]  = '{0, 0, 1, 0, 0, 32'h00, 24'h0};
      vecs[1]  = '{0, 0, 0, 0, 0, 32'h00, 24'h0};
      vecs[2]  = '{0, 0, 1, 0, 1, 32'h04, 24'h0};
      vecs[3]  = '{0, 0, 0, 0, 1, 32'h04, 24'h0};
      vecs[4]  = '{0, 0, 1, 0, 1, 32'h08, 24'h0};
      vecs[5]  = '{0, 0, 0, 0, 1, 32'h08, 24'h0};
      vecs[6]  = '{0, 0, 1, 0, 1, 32'h0C, 24'h0};
      vecs[7]  = '{0, 0, 0, 0, 1, 32'h0C, 24'h0};
      vecs[8]  = '{0, 0, 0, 1, 1, 32'h10, 24'h0};
      vecs[9]  = '{0, 0, 0, 1, 1, 32'h10, 24'h0};
      vecs[10] = '{1, 0, 0, 1, 1, 32'h10, 24'h4};
      vecs[11] = '{0, 0, 1, 0, 1, 32'h10, 24'h4};
      vecs[12] = '{0, 0, 0, 0, 1, 32'h10, 24'h4};
      vecs[13] = '{0, 0, 0, 1, 1, 32'h14, 24'h4};

      mem_wait           = 0;
      reset              = 1'b0;
      mif.instr_ready    = 1'b0;
      mif.fetch_hold     = 1'b0;
      mif.redirect_valid = 1'b0;
      mif.redirect_pc    = '0;
      exp_pc             = '0;
      repeat (2) @(negedge clk);
      check("rst_rstrb", mif.mem_rstrb, 1'b0);
      check("rst_idle", mif.fetch_idle, 1'b1);
      check("rst_valid", mif.instr_valid, 1'b0);
      check("rst_addr", mif.mem_addr, 32'h0);
      reset = 1'b1;

      // Fill to full, then pop one and watch the refill at 0x10.
      for (int i = 0; i < 14; i++) begin
         mif.instr_ready = vecs[i].ready;
         mif.fetch_hold  = vecs[i].hold;
         tick();
         check($sformatf("vec%0d_rstrb", i), mif.mem_rstrb, vecs[i].rstrb);
         check($sformatf("vec%0d_idle", i), mif.fetch_idle, vecs[i].idle);
         check($sformatf("vec%0d_valid", i), mif.instr_valid, vecs[i].valid);
         check($sformatf("vec%0d_addr", i), mif.mem_addr, vecs[i].addr);
         if (vecs[i].valid) check($sformatf("vec%0d_pc", i), 32'(mif.instr_pc), 32'(vecs[i].pc));
         if (i == 9) fill_strobes = n_strobe;
      end
      check("fill_strobe_count", fill_strobes, 32'd4);
      mif.instr_ready = 1'b1;
      wait_pops(10, 60, "drain_progress");

      // Redirect while a read is held busy: stale word must not reach the queue.
      do_reset();
      mem_wait = 3;
      tick();
      tick();
      mif.redirect_valid = 1'b1;
      mif.redirect_pc    = 24'h000103;
      tick();
      mif.redirect_valid = 1'b0;
      check("drop_state", 32'(dut.r_state), 32'(DROP));
      check("drop_addr", mif.mem_addr, 32'h100);
      wait_strobe(20, "drop_refetch");
      check("drop_refetch_addr", mif.mem_addr, 32'h100);
      wait_valid(20, "drop_push");
      check("drop_first_pc", 32'(mif.instr_pc), 32'h100);
      mem_wait        = 0;
      mif.instr_ready = 1'b1;
      wait_pops(3, 40, "drop_pops");

      // Redirect coincident with a pop at count 3.
      do_reset();
      mem_wait = 0;
      repeat (7) tick();
      check("pre_redirect_count", 32'(dut.w_count), 32'd3);
      mif.instr_ready    = 1'b1;
      mif.redirect_valid = 1'b1;
      mif.redirect_pc    = 24'h000200;
      tick();
      mif.redirect_valid = 1'b0;
      mif.instr_ready    = 1'b0;
      check("flush_count", 32'(dut.w_count), 32'd0);
      check("flush_valid", mif.instr_valid, 1'b0);
      n_pops          = 0;
      mif.instr_ready = 1'b1;
      wait_pops(2, 40, "flush_pops");

      // Hold raised mid-read: the read still lands, then no strobe until release.
      do_reset();
      mem_wait = 2;
      tick();
      tick();
      mif.fetch_hold = 1'b1;
      wait_valid(10, "hold_push");
      check("hold_pc", 32'(mif.instr_pc), 32'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("hold_no_strobe", mif.mem_rstrb, 1'b0);
         check("hold_idle", mif.fetch_idle, 1'b1);
      end
      mif.fetch_hold = 1'b0;
      tick();
      check("hold_release_strobe", mif.mem_rstrb, 1'b1);

      // PC wrap at the top of the 24-bit space.
      do_reset();
      mem_wait = 0;
      tick();
      mif.redirect_valid = 1'b1;
      mif.redirect_pc    = 24'hFFFFFE;
      tick();
      mif.redirect_valid = 1'b0;
      wait_strobe(10, "wrap_strobe_a");
      check("wrap_addr_a", mif.mem_addr, 32'h00FF_FFFC);
      tick();
      wait_strobe(10, "wrap_strobe_b");
      check("wrap_addr_b", mif.mem_addr, 32'h0000_0000);
      n_pops          = 0;
      mif.instr_ready = 1'b1;
      wait_pops(3, 40, "wrap_pops");

      // Reset asserted mid-read returns outputs without waiting for a clock.
      mif.instr_ready = 1'b0;
      mem_wait        = 5;
      wait_strobe(20, "mid_strobe");
      tick();
      #1;
      reset = 1'b0;
      #1;
      check("async_rstrb", mif.mem_rstrb, 1'b0);
      check("async_idle", mif.fetch_idle, 1'b1);
      check("async_valid", mif.instr_valid, 1'b0);
      check("async_addr", mif.mem_addr, 32'h0);
      do_reset();
      mem_wait        = 0;
      n_pops          = 0;
      mif.instr_ready = 1'b1;
      wait_pops(4, 40, "post_reset_pops");

      // Random traffic against the sequential-stream model.
      do_reset();
      n_pops = 0;
      for (int c = 0; c < 3000; c++) begin
         mem_wait           = $urandom_range(0, 3);
         mif.instr_ready    = ($urandom_range(0, 2) != 0);
         mif.fetch_hold     = ($urandom_range(0, 7) == 0);
         mif.redirect_valid = ($urandom_range(0, 39) == 0);
         mif.redirect_pc    = AW'($urandom());
         tick();
      end
      check("random_progress", n_pops > 100, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
